// File: rtl/lsu.sv
// Load/store unit: turns an ALU effective address plus store data into a single
// req/ready data-memory transaction, aligns and extends load data, and stalls
// the core until the access finishes. Misaligned or illegal-size requests and
// memory timeouts complete with err=1 and without reaching memory.
module lsu #(
   parameter int D_WIDTH = 32,
   parameter int TIMEOUT = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req_valid,
   input  logic               req_write,
   input  logic [1:0]         req_size,
   input  logic               req_unsigned,
   input  logic [D_WIDTH-1:0] addr,
   input  logic [D_WIDTH-1:0] wdata,
   output logic               stall,
   output logic               done,
   output logic               err,
   output logic [D_WIDTH-1:0] rdata,
   output logic               mem_req,
   output logic               mem_we,
   output logic [D_WIDTH-1:0] mem_addr,
   output logic [3:0]         mem_be,
   output logic [D_WIDTH-1:0] mem_wdata,
   input  logic               mem_ready,
   input  logic [D_WIDTH-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   // Counter only has to reach TIMEOUT-1; it may wrap harmlessly when disabled.
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   state_t         state;
   logic [CW-1:0]  cnt;
   logic [1:0]     lat_off;   // byte offset inside the word, for load alignment
   logic [1:0]     lat_size;
   logic           lat_uns;

   logic               aligned;
   logic [3:0]         be_nxt;
   logic [D_WIDTH-1:0] wdata_nxt;
   logic [D_WIDTH-1:0] ld_shift;
   logic [D_WIDTH-1:0] ld_ext;
   logic               timed_out;

   // Core must hold while a request is being accepted or is in flight.
   assign stall = ((state == IDLE) && req_valid) || (state == BUSY);

   // Request decode: alignment, byte enables and lane-replicated store data.
   always_comb begin
      aligned   = 1'b0;
      be_nxt    = 4'b0000;
      wdata_nxt = wdata;
      unique case (req_size)
         2'b00: begin
            aligned   = 1'b1;
            be_nxt    = 4'b0001 << addr[1:0];
            wdata_nxt = {4{wdata[7:0]}};
         end
         2'b01: begin
            aligned   = ~addr[0];
            be_nxt    = 4'b0011 << addr[1:0];
            wdata_nxt = {2{wdata[15:0]}};
         end
         2'b10: begin
            aligned   = (addr[1:0] == 2'b00);
            be_nxt    = 4'b1111;
         end
         default: aligned = 1'b0;
      endcase
   end

   // Load path: shift the addressed lane down, then sign/zero extend.
   always_comb begin
      ld_shift = mem_rdata >> {lat_off, 3'b000};
      ld_ext   = ld_shift;
      case (lat_size)
         2'b00:   ld_ext = lat_uns ? {{(D_WIDTH-8){1'b0}}, ld_shift[7:0]}
                                   : {{(D_WIDTH-8){ld_shift[7]}}, ld_shift[7:0]};
         2'b01:   ld_ext = lat_uns ? {{(D_WIDTH-16){1'b0}}, ld_shift[15:0]}
                                   : {{(D_WIDTH-16){ld_shift[15]}}, ld_shift[15:0]};
         default: ld_ext = ld_shift;
      endcase
   end

   assign timed_out = (TIMEOUT > 0) && (cnt == CNT_LAST) && !mem_ready;

   // Access sequencer; all bus and result outputs are registered here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         lat_off   <= 2'b00;
         lat_size  <= 2'b00;
         lat_uns   <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_be    <= 4'b0000;
         mem_wdata <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
         rdata     <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               done <= 1'b0;
               err  <= 1'b0;
               if (req_valid) begin
                  if (aligned) begin
                     mem_req   <= 1'b1;
                     mem_we    <= req_write;
                     mem_addr  <= {addr[D_WIDTH-1:2], 2'b00};
                     mem_be    <= be_nxt;
                     mem_wdata <= wdata_nxt;
                     lat_off   <= addr[1:0];
                     lat_size  <= req_size;
                     lat_uns   <= req_unsigned;
                     cnt       <= '0;
                     state     <= BUSY;
                  end else begin
                     done  <= 1'b1;
                     err   <= 1'b1;
                     rdata <= '0;
                     state <= DONE;
                  end
               end
            end
            BUSY: begin
               // mem_ready on the last allowed cycle wins over the timeout.
               if (mem_ready) begin
                  mem_req <= 1'b0;
                  rdata   <= mem_we ? '0 : ld_ext;
                  done    <= 1'b1;
                  err     <= 1'b0;
                  state   <= DONE;
               end else if (timed_out) begin
                  mem_req <= 1'b0;
                  rdata   <= '0;
                  done    <= 1'b1;
                  err     <= 1'b1;
                  state   <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               // req_valid here still belongs to the finished instruction.
               done  <= 1'b0;
               err   <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu, built with TIMEOUT=4 so the timeout path is short.
module tb_lsu;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_write = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic        stall, done, err, mem_req, mem_we;
   logic [31:0] rdata, mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_rdata = '0;

   int n_cmp = 0;
   int n_bad = 0;

   lsu #(.D_WIDTH(32), .TIMEOUT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
      .req_unsigned(req_unsigned), .addr(addr), .wdata(wdata),
      .stall(stall), .done(done), .err(err), .rdata(rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic w, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] d);
      req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns;
      addr = a; wdata = d;
   endtask

   // Core moves on after DONE: drop the request and return to IDLE.
   task automatic release_req();
      req_valid = 1'b0; mem_ready = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      #3;
      n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rst_mem_req got %b exp 0", mem_req); end
      n_cmp++; if (done !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL rst_done_err got %b%b exp 00", done, err); end
      n_cmp++; if (rdata !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_be !== 4'h0 || mem_we !== 1'b0)
         begin n_bad++; $display("FAIL rst_regs got rdata %h addr %h wd %h be %h we %b exp zeros", rdata, mem_addr, mem_wdata, mem_be, mem_we); end
      n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall got %b exp 0", stall); end
      #8 rst_n = 1'b1;
      tick();
   endtask

   task automatic test_word_load();
      issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
      #1;
      n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL wl_stall_idle got %b exp 1", stall); end
      tick();
      n_cmp++; if (mem_req !== 1'b1 || mem_we !== 1'b0) begin n_bad++; $display("FAIL wl_req got req %b we %b exp 1 0", mem_req, mem_we); end
      n_cmp++; if (mem_addr !== 32'h100 || mem_be !== 4'b1111) begin n_bad++; $display("FAIL wl_bus got addr %h be %b exp 100 1111", mem_addr, mem_be); end
      n_cmp++; if (stall !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL wl_busy got stall %b done %b exp 1 0", stall, done); end
      mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
      tick();
      n_cmp++; if (done !== 1'b1 || err !== 1'b0) begin n_bad++; $display("FAIL wl_done got done %b err %b exp 1 0", done, err); end
      n_cmp++; if (rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wl_rdata got %h exp deadbeef", rdata); end
      n_cmp++; if (stall !== 1'b0 || mem_req !== 1'b0) begin n_bad++; $display("FAIL wl_done_bus got stall %b req %b exp 0 0", stall, mem_req); end
      release_req();
      n_cmp++; if (done !== 1'b0 || rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wl_hold got done %b rdata %h exp 0 deadbeef", done, rdata); end
   endtask

   task automatic test_misaligned();
      logic [1:0] szs [2];
      logic [31:0] as [2];
      szs[0] = 2'b10; as[0] = 32'h101;
      szs[1] = 2'b11; as[1] = 32'h104;
      for (int k = 0; k < 2; k++) begin
         issue(1'b0, szs[k], 1'b0, as[k], 32'h0);
         mem_ready = 1'b1; mem_rdata = 32'h55555555;  // must be ignored outside BUSY
         #1;
         n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL mis%0d_stall got %b exp 1", k, stall); end
         tick();
         n_cmp++; if (done !== 1'b1 || err !== 1'b1) begin n_bad++; $display("FAIL mis%0d_done got done %b err %b exp 1 1", k, done, err); end
         n_cmp++; if (rdata !== 32'h0 || mem_req !== 1'b0) begin n_bad++; $display("FAIL mis%0d_noacc got rdata %h req %b exp 0 0", k, rdata, mem_req); end
         n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL mis%0d_stall_done got %b exp 0", k, stall); end
         release_req();
         n_cmp++; if (done !== 1'b0 || err !== 1'b0 || mem_req !== 1'b0) begin n_bad++; $display("FAIL mis%0d_idle got done %b err %b req %b exp 000", k, done, err, mem_req); end
      end
   endtask

   task automatic test_sub_word_load();
      logic [1:0]  szs [3];
      logic        us  [3];
      logic [31:0] as  [3];
      logic [3:0]  bes [3];
      logic [31:0] exp [3];
      szs[0] = 2'b00; us[0] = 1'b0; as[0] = 32'h103; bes[0] = 4'b1000; exp[0] = 32'hFFFFFF80;
      szs[1] = 2'b00; us[1] = 1'b1; as[1] = 32'h103; bes[1] = 4'b1000; exp[1] = 32'h00000080;
      szs[2] = 2'b01; us[2] = 1'b0; as[2] = 32'h102; bes[2] = 4'b1100; exp[2] = 32'hFFFF80AA;
      for (int k = 0; k < 3; k++) begin
         issue(1'b0, szs[k], us[k], as[k], 32'h0);
         tick();
         n_cmp++; if (mem_be !== bes[k] || mem_addr !== 32'h100) begin n_bad++; $display("FAIL ld%0d_bus got be %b addr %h exp %b 100", k, mem_be, mem_addr, bes[k]); end
         mem_ready = 1'b1; mem_rdata = 32'h80AABBCC;
         tick();
         n_cmp++; if (done !== 1'b1 || rdata !== exp[k]) begin n_bad++; $display("FAIL ld%0d_rdata got done %b rdata %h exp 1 %h", k, done, rdata, exp[k]); end
         release_req();
      end
   endtask

   task automatic test_timeout();
      // Run 0: memory never answers. Run 1: answers on the 4th cycle.
      for (int k = 0; k < 2; k++) begin
         issue(1'b0, 2'b10, 1'b0, 32'h500, 32'h0);
         mem_ready = 1'b0; mem_rdata = 32'h11223344;
         tick();
         for (int c = 0; c < 4; c++) begin
            if (k == 1 && c == 3) mem_ready = 1'b1;
            n_cmp++; if (mem_req !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL to%0d_req_c%0d got req %b done %b exp 1 0", k, c, mem_req, done); end
            tick();
         end
         n_cmp++; if (done !== 1'b1 || mem_req !== 1'b0) begin n_bad++; $display("FAIL to%0d_end got done %b req %b exp 1 0", k, done, mem_req); end
         n_cmp++; if (err !== (k == 0)) begin n_bad++; $display("FAIL to%0d_err got %b exp %b", k, err, (k == 0)); end
         n_cmp++; if (rdata !== ((k == 0) ? 32'h0 : 32'h11223344)) begin n_bad++; $display("FAIL to%0d_rdata got %h", k, rdata); end
         release_req();
      end
   endtask

   task automatic test_half_store();
      issue(1'b1, 2'b01, 1'b0, 32'h202, 32'h1234ABCD);
      tick();
      for (int c = 0; c < 4; c++) begin
         if (c == 3) mem_ready = 1'b1;
         n_cmp++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h200 || mem_be !== 4'b1100 || mem_wdata !== 32'hABCDABCD)
            begin n_bad++; $display("FAIL hs_c%0d got req %b we %b addr %h be %b wd %h exp 1 1 200 1100 abcdabcd", c, mem_req, mem_we, mem_addr, mem_be, mem_wdata); end
         tick();
      end
      n_cmp++; if (done !== 1'b1 || err !== 1'b0 || rdata !== 32'h0) begin n_bad++; $display("FAIL hs_done got done %b err %b rdata %h exp 1 0 0", done, err, rdata); end
      release_req();
   endtask

   task automatic test_byte_store();
      issue(1'b1, 2'b00, 1'b0, 32'h401, 32'h000000A5);
      tick();
      n_cmp++; if (mem_be !== 4'b0010 || mem_wdata !== 32'hA5A5A5A5 || mem_addr !== 32'h400) begin n_bad++; $display("FAIL bs_bus got be %b wd %h addr %h exp 0010 a5a5a5a5 400", mem_be, mem_wdata, mem_addr); end
      mem_ready = 1'b1;
      tick();
      n_cmp++; if (done !== 1'b1 || err !== 1'b0) begin n_bad++; $display("FAIL bs_done got done %b err %b exp 1 0", done, err); end
      release_req();
   endtask

   task automatic test_reset_busy();
      issue(1'b1, 2'b10, 1'b0, 32'h600, 32'h01020304);
      tick();
      n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL rb_req got %b exp 1", mem_req); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rb_drop got %b exp 0", mem_req); end
      req_valid = 1'b0; mem_ready = 1'b1;
      for (int c = 0; c < 2; c++) begin
         tick();
         n_cmp++; if (done !== 1'b0 || stall !== 1'b0) begin n_bad++; $display("FAIL rb_nodone_c%0d got done %b stall %b exp 0 0", c, done, stall); end
      end
      rst_n = 1'b1; mem_ready = 1'b0;
      tick();
      n_cmp++; if (done !== 1'b0 || mem_req !== 1'b0) begin n_bad++; $display("FAIL rb_post got done %b req %b exp 0 0", done, mem_req); end
      issue(1'b1, 2'b10, 1'b0, 32'h300, 32'hCAFEF00D);
      tick();
      n_cmp++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'b1111 || mem_wdata !== 32'hCAFEF00D || mem_addr !== 32'h300)
         begin n_bad++; $display("FAIL rb_store got req %b we %b be %b wd %h addr %h", mem_req, mem_we, mem_be, mem_wdata, mem_addr); end
      mem_ready = 1'b1;
      tick();
      n_cmp++; if (done !== 1'b1 || err !== 1'b0) begin n_bad++; $display("FAIL rb_done got done %b err %b exp 1 0", done, err); end
      release_req();
   endtask

   initial begin
      test_reset();
      test_word_load();
      test_misaligned();
      test_sub_word_load();
      test_timeout();
      test_half_store();
      test_byte_store();
      test_reset_busy();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
